// File: rtl/pipeline_writeback.sv
// pipeline_writeback: final pipeline stage. Commits memory-stage results into a
// 32-entry register file, serves two bypassed decode read ports, and sequences
// ECALLs through a request/done handshake while stalling the pipeline.
module pipeline_writeback #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_enable,
    input  logic [4:0]            wb_dst_reg,
    input  logic [DATA_WIDTH-1:0] wb_dst_val,
    input  logic                  ecall_wb,
    input  logic [4:0]            rs1_addr,
    input  logic [4:0]            rs2_addr,
    output logic [DATA_WIDTH-1:0] rs1_val,
    output logic [DATA_WIDTH-1:0] rs2_val,
    output logic                  stall,
    output logic                  ECALL_VALID,
    input  logic                  ECALL_READY,
    output logic [DATA_WIDTH-1:0] ECALL_NUM,
    output logic [DATA_WIDTH-1:0] ECALL_A0,
    output logic [DATA_WIDTH-1:0] ECALL_A1,
    output logic [DATA_WIDTH-1:0] ECALL_A2,
    input  logic                  ECALL_DONE,
    input  logic [DATA_WIDTH-1:0] ECALL_RET,
    output logic [63:0]           retire_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RET  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] regs_q [32];
    logic [DATA_WIDTH-1:0] num_q, a0_q, a1_q, a2_q, ret_q;
    logic [63:0]           retireCount_q, retireCount_d;
    logic                  latchArgs, latchRet, pipeWrite, retCommit;
    logic [DATA_WIDTH-1:0] argNum, argA0, argA1, argA2;

    // Register read with same-cycle bypass of the incoming writeback value.
    function automatic logic [DATA_WIDTH-1:0] bypassRead(input logic [4:0] addr);
        logic [DATA_WIDTH-1:0] value;
        value = regs_q[addr];
        if (addr == 5'd0) begin
            value = '0;
        end else if (wb_enable && (wb_dst_reg == addr)) begin
            value = wb_dst_val;
        end
        return value;
    endfunction

    // In RET the ECALL return value owns x10, so a pipeline write there is dropped.
    assign retCommit = (state_q == ST_RET);
    assign pipeWrite = wb_enable && (wb_dst_reg != 5'd0) &&
                       !(retCommit && (wb_dst_reg == 5'd10));

    // Decode read ports and the ECALL argument snapshot share the bypassed path.
    always_comb begin
        rs1_val = bypassRead(rs1_addr);
        rs2_val = bypassRead(rs2_addr);
        argNum  = bypassRead(5'd17);
        argA0   = bypassRead(5'd10);
        argA1   = bypassRead(5'd11);
        argA2   = bypassRead(5'd12);
    end

    // ECALL sequencer next-state logic, handshake outputs and stall.
    always_comb begin
        state_d     = state_q;
        latchArgs   = 1'b0;
        latchRet    = 1'b0;
        ECALL_VALID = 1'b0;
        stall       = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                stall = ecall_wb;
                if (ecall_wb) begin
                    latchArgs = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                ECALL_VALID = 1'b1;
                if (ECALL_READY) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ECALL_DONE) begin
                    latchRet = 1'b1;
                    state_d  = ST_RET;
                end
            end
            ST_RET: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Retired count: one per committed pipeline write, one per finished ECALL.
    always_comb begin
        retireCount_d = retireCount_q + 64'(pipeWrite) + 64'(retCommit);
    end

    // ECALL state register; reset aborts any outstanding call at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Register file storage, including the x10 return-value writeback.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (pipeWrite) begin
                regs_q[wb_dst_reg] <= wb_dst_val;
            end
            if (retCommit) begin
                regs_q[10] <= ret_q;
            end
        end
    end

    // Syscall argument/return latches and the retire counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num_q         <= '0;
            a0_q          <= '0;
            a1_q          <= '0;
            a2_q          <= '0;
            ret_q         <= '0;
            retireCount_q <= '0;
        end else begin
            if (latchArgs) begin
                num_q <= argNum;
                a0_q  <= argA0;
                a1_q  <= argA1;
                a2_q  <= argA2;
            end
            if (latchRet) begin
                ret_q <= ECALL_RET;
            end
            retireCount_q <= retireCount_d;
        end
    end

    assign ECALL_NUM    = num_q;
    assign ECALL_A0     = a0_q;
    assign ECALL_A1     = a1_q;
    assign ECALL_A2     = a2_q;
    assign retire_count = retireCount_q;

endmodule

// File: tb/tb_pipeline_writeback.sv
// tb_pipeline_writeback: randomized and directed stimulus for pipeline_writeback,
// checked every cycle against a behavioural register-file/ECALL model.
module tb_pipeline_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_enable;
    logic [4:0]  wb_dst_reg;
    logic [63:0] wb_dst_val;
    logic        ecall_wb;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [63:0] rs1_val, rs2_val;
    logic        stall;
    logic        ECALL_VALID;
    logic        ECALL_READY;
    logic [63:0] ECALL_NUM, ECALL_A0, ECALL_A1, ECALL_A2;
    logic        ECALL_DONE;
    logic [63:0] ECALL_RET;
    logic [63:0] retire_count;

    pipeline_writeback #(.DATA_WIDTH(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .wb_enable    (wb_enable),
        .wb_dst_reg   (wb_dst_reg),
        .wb_dst_val   (wb_dst_val),
        .ecall_wb     (ecall_wb),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_val      (rs1_val),
        .rs2_val      (rs2_val),
        .stall        (stall),
        .ECALL_VALID  (ECALL_VALID),
        .ECALL_READY  (ECALL_READY),
        .ECALL_NUM    (ECALL_NUM),
        .ECALL_A0     (ECALL_A0),
        .ECALL_A1     (ECALL_A1),
        .ECALL_A2     (ECALL_A2),
        .ECALL_DONE   (ECALL_DONE),
        .ECALL_RET    (ECALL_RET),
        .retire_count (retire_count)
    );

    // Free-running pipeline clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    int vectorCount = 0;
    int missCount   = 0;
    int stallSeen   = 0;

    // Reference model: architectural registers, the outstanding call and its data.
    // callPhase: 0 = no call, 1 = offered to handler, 2 = handler busy, 3 = result due.
    logic [63:0] mRegs [32];
    int          callPhase;
    logic [63:0] mNum, mA0, mA1, mA2, mRet;
    logic [63:0] mRetire;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] modelRead(input logic [4:0] addr);
        if (addr == 5'd0) return 64'd0;
        if (wb_enable && wb_dst_reg == addr) return wb_dst_val;
        return mRegs[addr];
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 32; i++) mRegs[i] = 64'd0;
        callPhase = 0;
        mNum = 0; mA0 = 0; mA1 = 0; mA2 = 0; mRet = 0;
        mRetire = 0;
    endtask

    // Drive one cycle of inputs, check the settled outputs, then advance the model.
    task automatic applyStimulus(input logic we, input logic [4:0] dst, input logic [63:0] val,
                                 input logic ec, input logic rdy, input logic dn,
                                 input logic [63:0] ret, input logic [4:0] r1, input logic [4:0] r2);
        logic [63:0] nNum, nA0, nA1, nA2;
        logic        dropWrite;
        wb_enable = we; wb_dst_reg = dst; wb_dst_val = val; ecall_wb = ec;
        ECALL_READY = rdy; ECALL_DONE = dn; ECALL_RET = ret;
        rs1_addr = r1; rs2_addr = r2;
        #3;
        checkOutput("rs1_val", rs1_val, modelRead(r1));
        checkOutput("rs2_val", rs2_val, modelRead(r2));
        checkOutput("stall", 64'(stall), 64'((callPhase != 0) || ec));
        checkOutput("ECALL_VALID", 64'(ECALL_VALID), 64'(callPhase == 1));
        if (callPhase == 1) begin
            checkOutput("ECALL_NUM", ECALL_NUM, mNum);
            checkOutput("ECALL_A0", ECALL_A0, mA0);
            checkOutput("ECALL_A1", ECALL_A1, mA1);
            checkOutput("ECALL_A2", ECALL_A2, mA2);
        end
        checkOutput("retire_count", retire_count, mRetire);
        if (stall) stallSeen++;
        nNum = modelRead(5'd17); nA0 = modelRead(5'd10);
        nA1 = modelRead(5'd11);  nA2 = modelRead(5'd12);
        @(posedge clk);
        dropWrite = (callPhase == 3) && (dst == 5'd10);
        if (we && dst != 5'd0 && !dropWrite) begin
            mRegs[dst] = val;
            mRetire = mRetire + 64'd1;
        end
        case (callPhase)
            0: if (ec) begin
                   mNum = nNum; mA0 = nA0; mA1 = nA1; mA2 = nA2;
                   callPhase = 1;
               end
            1: if (rdy) callPhase = 2;
            2: if (dn) begin mRet = ret; callPhase = 3; end
            default: begin
                mRegs[10] = mRet;
                mRetire = mRetire + 64'd1;
                callPhase = 0;
            end
        endcase
        #1;
    endtask

    task automatic idleCycle(input logic [4:0] r1, input logic [4:0] r2);
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0, r1, r2);
    endtask

    initial begin
        logic [4:0]  dst, r1, r2;
        logic [63:0] val;
        reset = 1'b0;
        wb_enable = 0; wb_dst_reg = 0; wb_dst_val = 0; ecall_wb = 0;
        ECALL_READY = 0; ECALL_DONE = 0; ECALL_RET = 0; rs1_addr = 0; rs2_addr = 0;
        modelReset();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        $display("[TB] reset released");
        #1;
        checkOutput("reset_retire", retire_count, 64'd0);
        checkOutput("reset_stall", 64'(stall), 64'd0);
        checkOutput("reset_valid", 64'(ECALL_VALID), 64'd0);
        checkOutput("reset_num", ECALL_NUM, 64'd0);
        #2;

        // Basic commit, x0 discard and next-cycle readback.
        applyStimulus(1'b1, 5'd5, 64'h1234, 1'b0, 1'b0, 1'b0, 64'd0, 5'd1, 5'd2);
        applyStimulus(1'b1, 5'd0, 64'hFF, 1'b0, 1'b0, 1'b0, 64'd0, 5'd5, 5'd0);
        idleCycle(5'd5, 5'd0);
        checkOutput("x5_direct", rs1_val, 64'h1234);
        checkOutput("retire_one", retire_count, 64'd1);

        // Same-cycle bypass on a fresh value of x7.
        applyStimulus(1'b1, 5'd7, 64'h11, 1'b0, 1'b0, 1'b0, 64'd0, 5'd7, 5'd7);
        applyStimulus(1'b1, 5'd7, 64'hAA, 1'b0, 1'b0, 1'b0, 64'd0, 5'd7, 5'd5);

        // ECALL with handler ready and done on the first wait cycle.
        applyStimulus(1'b1, 5'd17, 64'd93, 1'b0, 1'b0, 1'b0, 64'd0, 5'd17, 5'd0);
        applyStimulus(1'b1, 5'd10, 64'd3, 1'b0, 1'b0, 1'b0, 64'd0, 5'd10, 5'd0);
        stallSeen = 0;
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 1'b1, 1'b0, 64'd0, 5'd10, 5'd17);
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd0, 5'd10, 5'd17);
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 1'b1, 1'b1, 64'h55, 5'd10, 5'd17);
        idleCycle(5'd10, 5'd17);
        idleCycle(5'd10, 5'd17);
        checkOutput("stall_cycles", 64'(stallSeen), 64'd4);
        checkOutput("x10_ret", rs1_val, 64'h55);

        // Handler holds off for five cycles; request must stay stable.
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 1'b0, 1'b0, 64'd0, 5'd1, 5'd2);
        for (int i = 0; i < 5; i++) idleCycle(5'd10, 5'd11);
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd0, 5'd1, 5'd2);
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b1, 64'h66, 5'd1, 5'd2);
        idleCycle(5'd10, 5'd0);
        idleCycle(5'd10, 5'd0);

        // Pipeline write in RET: x10 loses to the return value, x11 commits alongside.
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 1'b1, 1'b0, 64'd0, 5'd0, 5'd0);
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd0, 5'd0, 5'd0);
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b1, 64'h77, 5'd0, 5'd0);
        applyStimulus(1'b1, 5'd10, 64'h99, 1'b0, 1'b0, 1'b0, 64'd0, 5'd10, 5'd0);
        idleCycle(5'd10, 5'd0);
        checkOutput("x10_wins", rs1_val, 64'h77);
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 1'b1, 1'b0, 64'd0, 5'd0, 5'd0);
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd0, 5'd0, 5'd0);
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b1, 64'h88, 5'd0, 5'd0);
        applyStimulus(1'b1, 5'd11, 64'h99, 1'b0, 1'b0, 1'b0, 64'd0, 5'd10, 5'd11);
        idleCycle(5'd10, 5'd11);

        // Randomized traffic, biased toward the ECALL argument registers.
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 7))
                0: dst = 5'd10;
                1: dst = 5'd11;
                2: dst = 5'd12;
                3: dst = 5'd17;
                default: dst = 5'($urandom_range(0, 31));
            endcase
            r1  = 5'($urandom_range(0, 31));
            r2  = ($urandom_range(0, 3) == 0) ? dst : 5'($urandom_range(0, 31));
            val = {$urandom, $urandom};
            applyStimulus(1'($urandom_range(0, 1)), dst, val,
                          ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 2) == 0), {$urandom, $urandom}, r1, r2);
        end
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 1'b1, 1'b1, 64'hABC, 5'd10, 5'd17);

        // Reset asserted while waiting on the handler aborts everything at once.
        applyStimulus(1'b1, 5'd20, 64'h3C, 1'b1, 1'b1, 1'b0, 64'd0, 5'd20, 5'd0);
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd0, 5'd20, 5'd0);
        wb_enable = 0; ecall_wb = 0; ECALL_READY = 0; ECALL_DONE = 0;
        reset = 1'b0;
        #1;
        checkOutput("abort_valid", 64'(ECALL_VALID), 64'd0);
        checkOutput("abort_stall", 64'(stall), 64'd0);
        checkOutput("abort_retire", retire_count, 64'd0);
        for (int i = 1; i < 32; i++) begin
            rs1_addr = 5'(i);
            #0.1;
            checkOutput("abort_regs", rs1_val, 64'd0);
        end
        modelReset();
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) idleCycle(5'd10, 5'd20);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
